// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cla_adder_pipe
//  Description : Parametrised pipelined two-level carry-lookahead
//                adder/subtractor with status flags and a stall-all
//                valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_adder_pipe #(
  parameter int WIDTH  = 16,  // operand width, multiple of GROUP, >= 4
  parameter int GROUP  = 4,   // bits per lookahead group
  parameter int STAGES = 2    // register stages from accept to output, 1..3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             c_out,
  output logic             ovf,
  output logic             zr,
  output logic             ng
);

  localparam int NGRP = WIDTH / GROUP;

  // Front-end result: bit propagate/generate, group P/G, effective carry in.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gg;
    logic             cin;
  } front_t;

  // Middle result: bit propagate/generate plus every group carry-in.
  // cg[NGRP] is the carry out of the MSB.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NGRP:0]    cg;
  } carry_t;

  // Final result as held in the output register.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zr;
  } res_t;

  // --------------------------------------------------------------------------
  // First level: operand conditioning and per-group propagate/generate.
  // Subtraction is a + ~b + 1, so the effective carry in is forced high.
  // --------------------------------------------------------------------------
  function automatic front_t f_front(input logic [WIDTH-1:0] fa,
                                     input logic [WIDTH-1:0] fb,
                                     input logic             fc,
                                     input logic             fs);
    front_t           r;
    logic [WIDTH-1:0] bx;
    logic             pp;
    logic             gg;
    bx    = fs ? ~fb : fb;
    r.p   = fa ^ bx;
    r.g   = fa & bx;
    r.cin = fs | fc;
    r.gp  = '0;
    r.gg  = '0;
    for (int k = 0; k < NGRP; k++) begin
      pp = 1'b1;
      gg = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        gg = r.g[k*GROUP+i] | (r.p[k*GROUP+i] & gg);
        pp = pp & r.p[k*GROUP+i];
      end
      r.gp[k] = pp;
      r.gg[k] = gg;
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Second level: each group carry is the sum-of-products of lower group
  // P/G terms and the carry in; synthesis flattens the inner loop.
  // --------------------------------------------------------------------------
  function automatic carry_t f_carry(input front_t f);
    carry_t r;
    logic   acc;
    r.p     = f.p;
    r.g     = f.g;
    r.cg    = '0;
    r.cg[0] = f.cin;
    for (int k = 0; k < NGRP; k++) begin
      acc = f.cin;
      for (int j = 0; j <= k; j++) begin
        acc = f.gg[j] | (f.gp[j] & acc);
      end
      r.cg[k+1] = acc;
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Final sum: in-group carries from the group carry-in, then flags.
  // Operand signs match exactly when the MSB propagate is 0, and in that
  // case the MSB generate equals the common sign bit.
  // --------------------------------------------------------------------------
  function automatic res_t f_final(input carry_t f);
    res_t r;
    logic c;
    r.sum = '0;
    for (int k = 0; k < NGRP; k++) begin
      c = f.cg[k];
      for (int i = 0; i < GROUP; i++) begin
        r.sum[k*GROUP+i] = f.p[k*GROUP+i] ^ c;
        c = f.g[k*GROUP+i] | (f.p[k*GROUP+i] & c);
      end
    end
    r.cout = f.cg[NGRP];
    r.ovf  = ~f.p[WIDTH-1] & (r.sum[WIDTH-1] ^ f.g[WIDTH-1]);
    r.zr   = ~|r.sum;
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake: the whole pipe moves when the output slot is free or drained.
  // --------------------------------------------------------------------------
  logic   rdy_q;
  logic   out_valid_q;
  res_t   res_q;
  logic   w_advance;
  logic   w_accept;
  logic   out_valid_d;
  res_t   res_d;

  assign w_advance = !out_valid_q | out_ready;
  assign in_ready  = rdy_q & w_advance;
  assign w_accept  = in_valid & in_ready;

  // Hold off input acceptance until one cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  // --------------------------------------------------------------------------
  // Stage placement by depth.
  // --------------------------------------------------------------------------
  generate
    if (STAGES <= 1) begin : g_st1
      assign out_valid_d = w_accept;
      assign res_d       = f_final(f_carry(f_front(a, b, c_in, sub)));
    end else if (STAGES == 2) begin : g_st2
      front_t s1_q;
      logic   s1_vld_q;

      // Front-end register: conditioned operands and group P/G.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_vld_q <= 1'b0;
          s1_q     <= '0;
        end else if (w_advance) begin
          s1_vld_q <= w_accept;
          if (w_accept) s1_q <= f_front(a, b, c_in, sub);
        end
      end

      assign out_valid_d = s1_vld_q;
      assign res_d       = f_final(f_carry(s1_q));
    end else begin : g_st3
      front_t s1_q;
      logic   s1_vld_q;
      carry_t s2_q;
      logic   s2_vld_q;

      // Front-end register: conditioned operands and group P/G.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_vld_q <= 1'b0;
          s1_q     <= '0;
        end else if (w_advance) begin
          s1_vld_q <= w_accept;
          if (w_accept) s1_q <= f_front(a, b, c_in, sub);
        end
      end

      // Middle register: resolved group carries.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_vld_q <= 1'b0;
          s2_q     <= '0;
        end else if (w_advance) begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) s2_q <= f_carry(s1_q);
        end
      end

      assign out_valid_d = s2_vld_q;
      assign res_d       = f_final(s2_q);
    end
  endgenerate

  // Output register: loads only on a real beat so results hold across
  // bubbles and stalls; flags travel with the sum they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (w_advance) begin
      out_valid_q <= out_valid_d;
      if (out_valid_d) res_q <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign o         = res_q.sum;
  assign c_out     = res_q.cout;
  assign ovf       = res_q.ovf;
  assign zr        = res_q.zr;
  assign ng        = res_q.sum[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_adder_pipe
//  Description : Directed self-checking bench for cla_adder_pipe
//                (16-bit two-stage instance plus 8-bit one/three-stage).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] o;
  logic        c_out;
  logic        ovf;
  logic        zr;
  logic        ng;

  logic       v8, c8, s8;
  logic [7:0] a8, b8;
  logic       rdy_s1, rdy_s3, ov_s1, ov_s3;
  logic [7:0] o_s1, o_s3;
  logic       co_s1, co_s3, vf_s1, vf_s3, zr_s1, zr_s3, ng_s1, ng_s3;

  int checks   = 0;
  int failures = 0;

  cla_adder_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .c_out(c_out), .ovf(ovf), .zr(zr), .ng(ng)
  );

  cla_adder_pipe #(.WIDTH(8), .GROUP(4), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy_s1),
    .a(a8), .b(b8), .c_in(c8), .sub(s8),
    .out_valid(ov_s1), .out_ready(1'b1),
    .o(o_s1), .c_out(co_s1), .ovf(vf_s1), .zr(zr_s1), .ng(ng_s1)
  );

  cla_adder_pipe #(.WIDTH(8), .GROUP(4), .STAGES(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy_s3),
    .a(a8), .b(b8), .c_in(c8), .sub(s8),
    .out_valid(ov_s3), .out_ready(1'b1),
    .o(o_s3), .c_out(co_s3), .ovf(vf_s3), .zr(zr_s3), .ng(ng_s3)
  );

  // Single beat through the idle 16-bit pipe; returns result and latency.
  task automatic run_beat(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts,
                          output logic [15:0] ro, output logic [3:0] rf,
                          output int lat);
    @(negedge clk);
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ro = o;
    rf = {c_out, ovf, zr, ng};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; s8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (o !== 16'h0000) begin failures++; $display("FAIL reset_o got=%h exp=0000", o); end
    checks++; if ({c_out, ovf, zr, ng} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {c_out, ovf, zr, ng}); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_no_beat got=%b exp=0", out_valid); end
  endtask

  task automatic test_arith();
    // {a, b, c_in, sub, o, {c_out, ovf, zr, ng}}
    logic [53:0] vec [10] = '{
      {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101},
      {16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b1010},
      {16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 4'b1010},
      {16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 4'b0001},
      {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b1100},
      {16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 4'b0000},
      {16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 4'b0000},
      {16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 4'b1001},
      {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 4'b1110},
      {16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 4'b0001}
    };
    logic [53:0] v;
    logic [15:0] ro;
    logic [3:0]  rf;
    int          lat;
    for (int k = 0; k < 10; k++) begin
      v = vec[k];
      run_beat(v[53:38], v[37:22], v[21], v[20], ro, rf, lat);
      checks++; if (lat != 1) begin failures++; $display("FAIL arith_latency[%0d] got=%0d exp=1", k, lat); end
      checks++; if (ro !== v[19:4]) begin failures++; $display("FAIL arith_o[%0d] got=%h exp=%h", k, ro, v[19:4]); end
      checks++; if (rf !== v[3:0]) begin failures++; $display("FAIL arith_flags[%0d] got=%b exp=%b", k, rf, v[3:0]); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] ro;
    logic [3:0]  rf;
    int          lat;
    run_beat(16'h0001, 16'h0001, 1'b0, 1'b1, ro, rf, lat);
    checks++; if (ro !== 16'h0000 || rf !== 4'b1010) begin failures++; $display("FAIL hold_result got=%h/%b exp=0000/1010", ro, rf); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_out_valid got=%b exp=0", out_valid); end
    checks++; if (o !== 16'h0000 || {c_out, ovf, zr, ng} !== 4'b1010) begin failures++; $display("FAIL hold_value got=%h/%b exp=0000/1010", o, {c_out, ovf, zr, ng}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    logic [15:0] tb [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] te [4] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    int   sent, got, first, last;
    logic acc;
    sent = 0; got = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
      @(negedge clk);
      if (sent < 4) begin
        in_valid = 1'b1; a = ta[sent]; b = tb[sent]; c_in = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        checks++; if (o !== te[got]) begin failures++; $display("FAIL b2b_o[%0d] got=%h exp=%h", got, o, te[got]); end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (got != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got); end
    checks++; if (first != 2 || last != 5) begin failures++; $display("FAIL b2b_timing got=%0d..%0d exp=2..5", first, last); end
  endtask

  task automatic test_backpressure();
    logic [15:0] ta [6] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
    logic [15:0] te [6] = '{16'h0111, 16'h0122, 16'h0133, 16'h0144, 16'h0155, 16'h0166};
    int   sent, got, last, gaps;
    logic acc;
    sent = 0; got = 0; last = -1; gaps = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ta[sent]; b = 16'h0100; c_in = 1'b0; sub = 1'b0;
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    checks++; if (sent != 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", sent); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || o !== 16'h0111) begin failures++; $display("FAIL bp_stall_hold got=%b/%h exp=1/0111", out_valid, o); end
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < 6) begin
        in_valid = 1'b1; a = ta[sent]; b = 16'h0100;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        checks++; if (o !== te[got]) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", got, o, te[got]); end
        if (last >= 0 && cyc != last + 1) gaps++;
        last = cyc;
        got++;
      end
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (got != 6 || sent != 6) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=6/6", got, sent); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL bp_gaps got=%0d exp=0", gaps); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] ro;
    logic [3:0]  rf;
    int          lat;
    int          spurious;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h0AAA; b = 16'h0001; c_in = 1'b0; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0BBB;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || o !== 16'h0AAB) begin failures++; $display("FAIL mid_before got=%b/%h exp=1/0aab", out_valid, o); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || o !== 16'h0000) begin failures++; $display("FAIL mid_async got=%b/%h exp=0/0000", out_valid, o); end
    checks++; if ({c_out, ovf, zr, ng} !== 4'b0000) begin failures++; $display("FAIL mid_flags got=%b exp=0000", {c_out, ovf, zr, ng}); end
    #1;
    rst = 1'b0;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) spurious++;
    end
    checks++; if (spurious != 0) begin failures++; $display("FAIL mid_discard got=%0d exp=0", spurious); end
    run_beat(16'h0CCC, 16'h0001, 1'b0, 1'b0, ro, rf, lat);
    checks++; if (ro !== 16'h0CCD || lat != 1) begin failures++; $display("FAIL mid_after got=%h/%0d exp=0ccd/1", ro, lat); end
  endtask

  task automatic test_stages();
    logic [7:0] ta [4] = '{8'h7F, 8'h05, 8'hF0, 8'h80};
    logic [7:0] tb [4] = '{8'h01, 8'h07, 8'h10, 8'h01};
    logic       tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       ts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    // {o, c_out, ovf, zr, ng}
    logic [11:0] te [4] = '{{8'h80, 4'b0101}, {8'hFE, 4'b0001},
                            {8'h01, 4'b1000}, {8'h7F, 4'b1100}};
    logic [11:0] r1, r3;
    int          lat1, lat3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a8 = ta[k]; b8 = tb[k]; c8 = tc[k]; s8 = ts[k]; v8 = 1'b1;
      #1;
      checks++; if ({rdy_s1, rdy_s3} !== 2'b11) begin failures++; $display("FAIL stg_ready[%0d] got=%b exp=11", k, {rdy_s1, rdy_s3}); end
      @(posedge clk);
      lat1 = -1; lat3 = -1; r1 = '0; r3 = '0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        v8 = 1'b0;
        #1;
        if (ov_s1 === 1'b1 && lat1 < 0) begin lat1 = c; r1 = {o_s1, co_s1, vf_s1, zr_s1, ng_s1}; end
        if (ov_s3 === 1'b1 && lat3 < 0) begin lat3 = c; r3 = {o_s3, co_s3, vf_s3, zr_s3, ng_s3}; end
        @(posedge clk);
      end
      checks++; if (lat1 != 0) begin failures++; $display("FAIL stg1_latency[%0d] got=%0d exp=0", k, lat1); end
      checks++; if (lat3 != 2) begin failures++; $display("FAIL stg3_latency[%0d] got=%0d exp=2", k, lat3); end
      checks++; if (r1 !== te[k]) begin failures++; $display("FAIL stg1_result[%0d] got=%h exp=%h", k, r1, te[k]); end
      checks++; if (r3 !== te[k]) begin failures++; $display("FAIL stg3_result[%0d] got=%h exp=%h", k, r3, te[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_hold();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_stages();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit combinational CLA.
- Generalised in WIDTH, lookahead GROUP size and pipeline depth STAGES. Adds a subtract mode, Hack-style status flags and a valid/ready handshake on input and output.
- Sits between the ALU operand muxes and the ALU result register. Multi-cycle arithmetic can be back-pressured by the writeback path.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP, minimum 4.
- GROUP, 4, bits per lookahead group (group P/G generated per GROUP bits, second-level lookahead across groups).
- STAGES, 2, register stages from input acceptance to output; legal range 1..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry in; ignored when sub=1.
- sub  in  1  0: o = a + b + c_in; 1: o = a + ~b + 1 (a - b).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result this cycle.
- o  out  WIDTH  sum/difference.
- c_out  out  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned).
- ovf  out  1  signed overflow: operand signs (after b inversion) equal and result sign differs.
- zr  out  1  o == 0.
- ng  out  1  o[WIDTH-1].

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, out_valid=0, o=0, c_out=0, ovf=0, zr=0, ng=0. in_ready=1 one cycle after release. Asserting rst mid-flight discards every in-flight beat; no partial result ever appears after release.
- Transfer rules:
  - Input beat accepted when in_valid & in_ready at a rising edge.
  - Output beat consumed when out_valid & out_ready.
  - Producer must hold a/b/c_in/sub stable while in_valid=1 and in_ready=0.
- Pipeline (stall-all):
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance=1, every stage shifts one step; bubbles shift as valid=0.
  - When advance=0, all stage registers hold.
- Latency:
  - A beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (STAGES=1: visible right after the accept edge).
  - Full throughput is one beat per cycle while out_ready=1.
  - Maximum occupancy is STAGES beats.
- Datapath split:
  - First stage registers per-group sums-without-carry, group P/G and the effective carry in (sub ? 1 : c_in).
  - The second-level lookahead plus final sum complete by the last stage.
  - For STAGES=3, the group carries are registered in the middle stage.
  - Exact split is free provided results and latency match.
- Arithmetic:
  - Full WIDTH+1-bit result: {c_out, o} = a + (sub ? ~b : b) + (sub ? 1 : c_in).
  - ovf = (A[msb] == B'[msb]) & (o[msb] != A[msb]), where B' is the inverted-if-sub operand.
  - zr, ng derived from the registered o, never from a stale value.
- Outputs o/c_out/ovf/zr/ng hold their last value while out_valid=0 and while stalled.
- Simultaneous events:
  - In the same cycle, accept and consume on a full pipeline is legal and keeps occupancy constant.
  - in_valid=0 while advancing inserts a bubble.

Test Plan:
- WIDTH=16, STAGES=2: a=0x7FFF, b=0x0001, c_in=0, sub=0 -> after 2 edges o=0x8000, c_out=0, ovf=1, ng=1, zr=0.
- a=0xFFFF, b=0x0000, c_in=1 -> o=0x0000, c_out=1, zr=1, ovf=0. Same with sub=1, a=b=0x1234 -> o=0, c_out=1, zr=1.
- sub=1, a=0x0005, b=0x0007, c_in=1 (ignored) -> o=0xFFFE, c_out=0, ng=1, ovf=0. sub=1, a=0x8000, b=0x0001 -> o=0x7FFF, ovf=1.
- Back-pressure, STAGES=2: stream 6 beats with out_ready=0 -> in_ready drops after exactly 2 accepts. Raise out_ready -> all 6 results emerge in order, one per cycle, none duplicated or dropped.
- Reset mid-flight: 2 beats in pipeline, pulse rst between edges -> out_valid=0 and o=0 immediately (async). After release, only beats accepted post-reset appear.
- Random/exhaustive vs behavioural model: WIDTH=8, GROUP=4, STAGES in {1,2,3}, all 2^17 a/b/c_in combos plus sub, with random in_valid/out_ready gaps -> every result and flag matches, and ordering is preserved.
